// File: rtl/channel_req_scheduler.sv
// channel_req_scheduler
// Accumulates per-channel request pulses into a pending mask and drains it one
// channel per grant, highest-numbered pending channel first. The grant is
// presented as a registered valid/ready stream carrying the channel index.
// The grant outputs come straight from flops, so grant_ready has no
// combinational path to them.

module channel_req_scheduler #(
  parameter int N     = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_load,
  input  logic [N-1:0]     req_in,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     pending,
  output logic             busy,
  output logic             overlap,
  output logic [CNT_W-1:0] grant_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;

  // Index of the highest set bit. The upward scan lets higher bits overwrite
  // lower ones, so bit N-1 has top priority. An all-zero input returns 0;
  // callers only use the result when the input is non-zero.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [N-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = i[IDX_W-1:0];
      end
    end
    return idx;
  endfunction

  // One-hot mask with a 1 at position idx.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] base;
    base = {{(N-1){1'b0}}, 1'b1};
    return base << idx;
  endfunction

  logic           acc;
  logic [N-1:0]   clr;
  logic [N-1:0]   ld;
  logic [N-1:0]   cand;
  logic [N-1:0]   pending_next;
  logic           overlap_next;
  logic           idle_next;
  logic           busy_next;

  // Accept, clear and load terms, and the next pending mask and flags.
  always_comb begin
    acc          = 1'b0;
    clr          = {N{1'b0}};
    ld           = {N{1'b0}};
    cand         = {N{1'b0}};
    pending_next = {N{1'b0}};
    overlap_next = 1'b0;
    idle_next    = 1'b1;
    busy_next    = 1'b0;

    acc = grant_valid & grant_ready;
    if (acc) begin
      clr = onehot(grant_idx);
    end else begin
      clr = {N{1'b0}};
    end
    if (req_load) begin
      ld = req_in;
    end else begin
      ld = {N{1'b0}};
    end
    // Candidates exclude this cycle's loads; a freshly loaded request
    // becomes eligible one cycle later.
    cand         = pending & ~clr;
    pending_next = cand | ld;
    // Flags a load that hits a bit that is still pending after this
    // cycle's accept. A bit re-requested while being accepted does not count.
    overlap_next = |(ld & cand);

    // Mirrors the FSM transitions below, so busy can be a flop.
    case (state)
      IDLE: begin
        idle_next = (pending == {N{1'b0}});
      end
      HOLD: begin
        idle_next = acc && (cand == {N{1'b0}});
      end
      default: begin
        idle_next = 1'b1;
      end
    endcase
    busy_next = ~idle_next | (pending_next != {N{1'b0}});
  end

  // Grant FSM plus pending mask, overlap pulse, accept counter and busy flag.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= {IDX_W{1'b0}};
      pending     <= {N{1'b0}};
      overlap     <= 1'b0;
      grant_cnt   <= {CNT_W{1'b0}};
      busy        <= 1'b0;
    end else begin
      pending <= pending_next;
      overlap <= overlap_next;
      busy    <= busy_next;
      if (acc) begin
        grant_cnt <= grant_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        grant_cnt <= grant_cnt;
      end

      case (state)
        IDLE: begin
          if (pending != {N{1'b0}}) begin
            grant_idx   <= prio_enc(pending);
            grant_valid <= 1'b1;
            state       <= HOLD;
          end else begin
            grant_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        HOLD: begin
          if (acc) begin
            if (cand != {N{1'b0}}) begin
              // Back-to-back grant with no bubble cycle.
              grant_idx   <= prio_enc(cand);
              grant_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end else begin
            // The offered grant stays stable until it is taken, even if a
            // higher-priority request shows up in the meantime.
            grant_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_req_scheduler.sv
// Self-checking bench for channel_req_scheduler: a per-cycle vector table plus
// hand-written multi-cycle sequences that check grant indices via a scoreboard queue.

module tb_channel_req_scheduler;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        req_load;
  logic [15:0] req_in;
  logic        grant_valid;
  logic        grant_ready;
  logic [3:0]  grant_idx;
  logic [15:0] pending;
  logic        busy;
  logic        overlap;
  logic [7:0]  grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  channel_req_scheduler #(.N(16), .IDX_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .req_load    (req_load),
    .req_in      (req_in),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_idx   (grant_idx),
    .pending     (pending),
    .busy        (busy),
    .overlap     (overlap),
    .grant_cnt   (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        ld;
    logic [15:0] rin;
    logic        rdy;
    logic        ev;
    logic [3:0]  eidx;
    logic [15:0] epend;
    logic        eov;
    logic [7:0]  ecnt;
    logic        ebusy;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; flush = 1'b0; req_load = 1'b0; req_in = 16'h0000;
  endtask

  // Runs cycles with ready=1, comparing every accepted index against the queue.
  task automatic drain(input int bound);
    int k;
    logic [3:0] e;
    k = 0;
    while (exp_q.size() > 0 && k < bound) begin
      if (grant_valid && grant_ready) begin
        e = exp_q.pop_front();
        chk("grant_idx_sb", {28'd0, grant_idx}, {28'd0, e});
      end
      step();
      k++;
    end
    chk("drain_done", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int accepts;
    int cyc;
    logic [3:0] e;

    idle_inputs();
    grant_ready = 1'b0;

    //             rst   fl    ld    rin       rdy  | ev   idx   pend      ov    cnt    busy
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h8001, 1'b1, 1'b0, 4'd0,  16'h8001, 1'b0, 8'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd15, 16'h8001, 1'b0, 8'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd0,  16'h0001, 1'b0, 8'd1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0006, 1'b0, 1'b0, 4'd0,  16'h0006, 1'b0, 8'd0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 4'd2,  16'h0006, 1'b1, 8'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd2,  16'h0006, 1'b0, 8'd0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd1,  16'h0002, 1'b0, 8'd1, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd1,  16'h0000, 1'b0, 8'd2, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 4'd0,  16'h0010, 1'b0, 8'd0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4'd4,  16'h0010, 1'b0, 8'd0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 4'd4,  16'h0010, 1'b0, 8'd1, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 4'd4,  16'h0010, 1'b0, 8'd1, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'd4,  16'h0000, 1'b0, 8'd2, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0, 4'd0,  16'h00FF, 1'b0, 8'd0, 1'b1};
    vecs[20] = '{1'b0, 1'b1, 1'b1, 16'h0F00, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0, 8'd0, 1'b0};

    // Table: one row per clock edge, outputs compared just after the edge.
    for (int r = 0; r < 21; r++) begin
      reset       = vecs[r].rst;
      flush       = vecs[r].fl;
      req_load    = vecs[r].ld;
      req_in      = vecs[r].rin;
      grant_ready = vecs[r].rdy;
      step();
      chk($sformatf("row%0d_valid", r),   {31'd0, grant_valid}, {31'd0, vecs[r].ev});
      chk($sformatf("row%0d_idx", r),     {28'd0, grant_idx},   {28'd0, vecs[r].eidx});
      chk($sformatf("row%0d_pending", r), {16'd0, pending},     {16'd0, vecs[r].epend});
      chk($sformatf("row%0d_overlap", r), {31'd0, overlap},     {31'd0, vecs[r].eov});
      chk($sformatf("row%0d_cnt", r),     {24'd0, grant_cnt},   {24'd0, vecs[r].ecnt});
      chk($sformatf("row%0d_busy", r),    {31'd0, busy},        {31'd0, vecs[r].ebusy});
    end

    // T2: a higher-priority request arriving during a stalled grant waits its turn.
    idle_inputs(); flush = 1'b1; grant_ready = 1'b0; step();
    flush = 1'b0;
    req_load = 1'b1; req_in = 16'h0010; exp_q.push_back(4'd4); step();
    req_load = 1'b0; step();
    step();
    chk("t2_idx_c2", {28'd0, grant_idx}, 32'd4);
    req_load = 1'b1; req_in = 16'h4000; exp_q.push_back(4'd14); step();
    req_load = 1'b0;
    chk("t2_idx_c3", {28'd0, grant_idx}, 32'd4);
    step();
    chk("t2_idx_c4", {28'd0, grant_idx}, 32'd4);
    chk("t2_pending", {16'd0, pending}, 32'h4010);
    grant_ready = 1'b1;
    drain(20);
    step();
    chk("t2_valid_end", {31'd0, grant_valid}, 32'd0);
    chk("t2_cnt", {24'd0, grant_cnt}, 32'd2);

    // T5: flush, then reset, while draining a full mask with ready=1.
    for (int pass = 0; pass < 2; pass++) begin
      idle_inputs(); flush = 1'b1; grant_ready = 1'b0; step();
      flush = 1'b0; grant_ready = 1'b1; req_load = 1'b1; req_in = 16'hFFFF;
      for (int c = 0; c < 5; c++) step();
      chk("t5_cnt_pre", {24'd0, grant_cnt}, 32'd3);
      chk("t5_valid_pre", {31'd0, grant_valid}, 32'd1);
      chk("t5_pending_pre", {16'd0, pending}, 32'hFFFF);
      if (pass == 0) flush = 1'b1;
      else reset = 1'b1;
      step();
      chk($sformatf("t5_valid_post%0d", pass), {31'd0, grant_valid}, 32'd0);
      chk($sformatf("t5_pending_post%0d", pass), {16'd0, pending}, 32'd0);
      chk($sformatf("t5_cnt_post%0d", pass), {24'd0, grant_cnt}, 32'd0);
      chk($sformatf("t5_busy_post%0d", pass), {31'd0, busy}, 32'd0);
    end

    // T6: reload 16'hFFFF each time the mask drains; 300 accepts wrap the counter.
    idle_inputs(); flush = 1'b1; grant_ready = 1'b0; step();
    flush = 1'b0; grant_ready = 1'b1;
    exp_q.delete();
    accepts = 0;
    cyc = 0;
    while (accepts < 300 && cyc < 1000) begin
      req_load = 1'b0; req_in = 16'h0000;
      if (grant_valid && grant_ready) begin
        if (exp_q.size() == 0) begin
          chk("t6_unexpected_grant", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("t6_idx", {28'd0, grant_idx}, {28'd0, e});
        end
        accepts++;
      end
      if (exp_q.size() == 0 && accepts < 300) begin
        req_load = 1'b1; req_in = 16'hFFFF;
        for (int k = 15; k >= 0; k--) exp_q.push_back(k[3:0]);
      end
      step();
      cyc++;
    end
    grant_ready = 1'b0; req_load = 1'b0;
    chk("t6_accepts", accepts, 32'd300);
    chk("t6_cnt_wrap", {24'd0, grant_cnt}, 32'd44);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
